jtgng_colmix: RTL and testbench

- Final video stage, directly downstream of the character layer.
- Each 6 MHz pixel it merges the char, scroll and object layer pixels by priority into an 8-bit palette index.
- Looks the index up in CPU-written palette RAM and drives 4-bit RGB with blanking aligned to the colour data.
- Feeds the video DAC / scan-doubler.

---
 rtl/jtgng_video_pkg.sv | 52 +++++
 rtl/jtgng_colmix_if.sv | 11 +
 rtl/jtgng_dual_ram.sv | 40 ++++
 rtl/jtgng_colmix.sv | 111 +++++++++++
 tb/tb_jtgng_colmix.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/jtgng_video_pkg.sv
// Shared video constants for the colour mixer and its palette RAMs.
package jtgng_video_pkg;

  // Transparent codes for each layer
  localparam logic [1:0] CHAR_TRANSP = 2'b11;
  localparam logic [2:0] SCR_TRANSP  = 3'b000;
  localparam logic [3:0] OBJ_TRANSP  = 4'hF;

  // Palette bank prefixes, top two bits of the palette index
  localparam logic [1:0] BANK_CHAR = 2'b11;
  localparam logic [1:0] BANK_OBJ  = 2'b01;
  localparam logic [1:0] BANK_SCR  = 2'b00;

  // Pixel-input to RGB latency in cen6 ticks
  localparam int COLMIX_LAT = 3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Layer priority: char over (obj unless a prioritised opaque scroll) over scroll.
  // A disabled layer is simply seen as transparent.
  function automatic logic [7:0] prio_pix(
    input logic [1:0] char_col,
    input logic [3:0] char_pal,
    input logic [2:0] scr_col,
    input logic [2:0] scr_pal,
    input logic       scr_prio,
    input logic [5:0] obj_pxl,
    input logic       char_on,
    input logic       scr_on,
    input logic       obj_on
  );
    logic       char_opq;
    logic       obj_opq;
    logic [2:0] scr_eff;
    logic [7:0] pix;
    char_opq = char_on && (char_col != CHAR_TRANSP);
    obj_opq  = obj_on  && (obj_pxl[3:0] != OBJ_TRANSP);
    scr_eff  = scr_on ? scr_col : SCR_TRANSP;
    if (char_opq)
      pix = {BANK_CHAR, char_pal, char_col};
    else if (obj_opq && !(scr_prio && (scr_eff != SCR_TRANSP)))
      pix = {BANK_OBJ, obj_pxl};
    else
      pix = {BANK_SCR, scr_pal, scr_eff};
    return pix;
  endfunction

endpackage

// File: rtl/jtgng_colmix_if.sv
// CPU palette write bus into the colour mixer.
interface jtgng_colmix_if;
  logic [7:0] AB;
  logic [7:0] din;
  logic       rd;
  logic       redgreen_cs;
  logic       blue_cs;

  modport cpu (output AB, din, rd, redgreen_cs, blue_cs);
  modport pal (input  AB, din, rd, redgreen_cs, blue_cs);
endinterface

// File: rtl/jtgng_dual_ram.sv
// 256x8 palette RAM: free-running CPU write port, cen-gated registered video read.
// A same-cycle write and read of one address returns the previous contents.
import jtgng_video_pkg::*;

module jtgng_dual_ram #(
  parameter string SIMFILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       we,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [0:255];
  logic [7:0] rd_data_q, rd_data_d;

  // CPU write port, not gated by the pixel enable
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Video read: sample the array only on pixel ticks
  always_comb begin
    rd_data_d = rd_data_q;
    if (cen) rd_data_d = mem[rd_addr];
  end

  // Read data register, cleared with the rest of the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/jtgng_colmix.sv
// Final colour mixer: layer priority -> palette lookup -> blanked 4-bit RGB.
import jtgng_video_pkg::*;

module jtgng_colmix #(
  parameter logic  CHAR_ON     = 1'b1,
  parameter logic  SCR_ON      = 1'b1,
  parameter logic  OBJ_ON      = 1'b1,
  parameter string PAL_SIMFILE = ""
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen6,
  input  logic [1:0] char_col,
  input  logic [3:0] char_pal,
  input  logic [2:0] scr_col,
  input  logic [2:0] scr_pal,
  input  logic       scr_prio,
  input  logic [5:0] obj_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  jtgng_colmix_if.pal cpu,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  logic [7:0]            pix_q, pix_d;
  logic [COLMIX_LAT-1:0] hb_pipe_q, hb_pipe_d;
  logic [COLMIX_LAT-1:0] vb_pipe_q, vb_pipe_d;
  rgb_t                  rgb_q, rgb_d;
  logic [7:0]            rg_data, b_data;
  logic                  rg_we, b_we;
  logic                  unused_b_lo;

  assign rg_we = cpu.redgreen_cs && !cpu.rd;
  assign b_we  = cpu.blue_cs     && !cpu.rd;

  // Stage 1 index and the blanking delay line
  always_comb begin
    pix_d     = pix_q;
    hb_pipe_d = hb_pipe_q;
    vb_pipe_d = vb_pipe_q;
    if (cen6) begin
      pix_d     = prio_pix(char_col, char_pal, scr_col, scr_pal, scr_prio, obj_pxl,
                           CHAR_ON, SCR_ON, OBJ_ON);
      hb_pipe_d = {hb_pipe_q[COLMIX_LAT-2:0], LHBL};
      vb_pipe_d = {vb_pipe_q[COLMIX_LAT-2:0], LVBL};
    end
  end

  // Stage 3 colour, zeroed when the blanking entering stage 3 is active
  always_comb begin
    rgb_d = rgb_q;
    if (cen6) begin
      if (hb_pipe_q[COLMIX_LAT-2] && vb_pipe_q[COLMIX_LAT-2])
        rgb_d = '{r: rg_data[7:4], g: rg_data[3:0], b: b_data[7:4]};
      else
        rgb_d = '0;
    end
  end

  // Pipeline registers; blanking resets to the blanked state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q     <= '0;
      hb_pipe_q <= '0;
      vb_pipe_q <= '0;
      rgb_q     <= '0;
    end else begin
      pix_q     <= pix_d;
      hb_pipe_q <= hb_pipe_d;
      vb_pipe_q <= vb_pipe_d;
      rgb_q     <= rgb_d;
    end
  end

  // Stage 2: both palettes looked up by the stage-1 index
  jtgng_dual_ram #(.SIMFILE(PAL_SIMFILE)) u_rg_ram (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen6),
    .we      (rg_we),
    .wr_addr (cpu.AB),
    .wr_data (cpu.din),
    .rd_addr (pix_q),
    .rd_data (rg_data)
  );

  jtgng_dual_ram #(.SIMFILE(PAL_SIMFILE)) u_b_ram (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen6),
    .we      (b_we),
    .wr_addr (cpu.AB),
    .wr_data (cpu.din),
    .rd_addr (pix_q),
    .rd_data (b_data)
  );

  // Only the upper nibble of the blue RAM carries colour
  assign unused_b_lo = ^b_data[3:0];

  assign red      = rgb_q.r;
  assign green    = rgb_q.g;
  assign blue     = rgb_q.b;
  assign LHBL_dly = hb_pipe_q[COLMIX_LAT-1];
  assign LVBL_dly = vb_pipe_q[COLMIX_LAT-1];

endmodule

// File: tb/tb_jtgng_colmix.sv
// Bench for jtgng_colmix: directed priority/blanking/collision cases plus random pixels,
// checked against a palette array model with an index/lookup/output delay line.
module tb_jtgng_colmix;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen6 = 1'b0;
  logic [1:0] char_col = 2'd3;
  logic [3:0] char_pal = 4'd0;
  logic [2:0] scr_col = 3'd0;
  logic [2:0] scr_pal = 3'd0;
  logic       scr_prio = 1'b0;
  logic [5:0] obj_pxl = 6'h0F;
  logic       LHBL = 1'b1;
  logic       LVBL = 1'b1;
  wire  [3:0] red, green, blue;
  wire        LHBL_dly, LVBL_dly;

  jtgng_colmix_if cpu_if();

  jtgng_colmix dut (
    .clk      (clk),
    .rst      (rst),
    .cen6     (cen6),
    .char_col (char_col),
    .char_pal (char_pal),
    .scr_col  (scr_col),
    .scr_pal  (scr_pal),
    .scr_prio (scr_prio),
    .obj_pxl  (obj_pxl),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .cpu      (cpu_if),
    .red      (red),
    .green    (green),
    .blue     (blue),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rg_ref [256];
  logic [7:0]  b_ref  [256];
  int          idx_h  [1024];
  bit          hb_h   [1024];
  bit          vb_h   [1024];
  logic [15:0] look_h [1024];
  int          p = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Palette index from the layer rules, in plain arithmetic
  function automatic int idx_of(input int cc, input int cp, input int sc, input int sp,
                                input int spr, input int op);
    if (cc != 3) return 192 + cp * 4 + cc;
    if ((op % 16) != 15 && !(spr != 0 && sc != 0)) return 64 + op;
    return sp * 8 + sc;
  endfunction

  // One clk edge; a CPU write on the bus lands in the model after the edge
  task automatic tick(input bit c);
    cen6 = c;
    @(posedge clk);
    #1;
    if (!cpu_if.rd) begin
      if (cpu_if.redgreen_cs) rg_ref[cpu_if.AB] = cpu_if.din;
      if (cpu_if.blue_cs)     b_ref[cpu_if.AB]  = cpu_if.din;
    end
    cpu_if.redgreen_cs = 1'b0;
    cpu_if.blue_cs     = 1'b0;
    cen6 = 1'b0;
  endtask

  task automatic set_wr(input logic [7:0] a, input logic [7:0] d, input bit to_rg, input bit to_b);
    cpu_if.AB = a;
    cpu_if.din = d;
    cpu_if.rd = 1'b0;
    cpu_if.redgreen_cs = to_rg;
    cpu_if.blue_cs = to_b;
  endtask

  // One pixel: cen6 tick plus three idle clocks, checking the pixel two steps back
  task automatic pix_step();
    logic [11:0] exp_rgb;
    logic [1:0]  exp_bl;
    if (p >= 1) look_h[p-1] = {rg_ref[idx_h[p-1]], b_ref[idx_h[p-1]]};
    idx_h[p] = idx_of(int'(char_col), int'(char_pal), int'(scr_col), int'(scr_pal),
                      int'(scr_prio), int'(obj_pxl));
    hb_h[p] = LHBL;
    vb_h[p] = LVBL;
    tick(1'b1);
    exp_rgb = '0;
    exp_bl  = '0;
    if (p >= 2) begin
      exp_bl = {hb_h[p-2], vb_h[p-2]};
      if (hb_h[p-2] && vb_h[p-2]) exp_rgb = {look_h[p-2][15:8], look_h[p-2][7:4]};
    end
    check($sformatf("pix%0d", p), {18'd0, red, green, blue, LHBL_dly, LVBL_dly},
          {18'd0, exp_rgb, exp_bl});
    p++;
    repeat (3) tick(1'b0);
  endtask

  task automatic set_pix(input logic [1:0] cc, input logic [3:0] cp, input logic [2:0] sc,
                         input logic [2:0] sp, input logic spr, input logic [5:0] op);
    char_col = cc; char_pal = cp; scr_col = sc; scr_pal = sp; scr_prio = spr; obj_pxl = op;
  endtask

  task automatic check_idx(input string tag, input int idx);
    check(tag, {20'd0, red, green, blue}, {20'd0, rg_ref[idx], b_ref[idx][7:4]});
  endtask

  initial begin
    cpu_if.AB = '0; cpu_if.din = '0; cpu_if.rd = 1'b1;
    cpu_if.redgreen_cs = 1'b0; cpu_if.blue_cs = 1'b0;

    // Reset state
    #5;
    check("reset_out", {27'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    p = 0;

    // Fill both palettes with cen6 low; the pipeline must not move
    for (int a = 0; a < 256; a++) begin
      set_wr(a[7:0], 8'($urandom), 1'b1, 1'b0); tick(1'b0);
      set_wr(a[7:0], 8'($urandom), 1'b0, 1'b1); tick(1'b0);
    end
    set_wr(8'hC5, 8'hA3, 1'b1, 1'b0); tick(1'b0);
    set_wr(8'hC5, 8'h70, 1'b0, 1'b1); tick(1'b0);
    set_wr(8'h40, 8'h00, 1'b1, 1'b1); tick(1'b0);
    check("idle_out", {27'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);

    // Char wins over opaque object and scroll
    set_pix(2'd1, 4'd1, 3'd4, 3'd2, 1'b1, 6'h12);
    repeat (3) pix_step();
    check("char_rgb", {20'd0, red, green, blue}, 32'h0000_0A37);

    // Prioritised scroll over object, then object over scroll
    set_pix(2'd3, 4'd0, 3'd2, 3'd5, 1'b1, 6'h12);
    repeat (3) pix_step();
    check_idx("scr_over_obj", 8'h2A);
    scr_prio = 1'b0;
    repeat (3) pix_step();
    check_idx("obj_over_scr", 8'h52);

    // Everything transparent: backdrop of the scroll palette
    set_pix(2'd3, 4'd9, 3'd0, 3'd3, 1'b1, 6'h3F);
    repeat (3) pix_step();
    check_idx("backdrop", 8'h18);

    // One-pixel horizontal blank, then a vertical blank pixel
    set_pix(2'd1, 4'd1, 3'd0, 3'd0, 1'b0, 6'h0F);
    pix_step();
    LHBL = 1'b0; pix_step();
    LHBL = 1'b1; pix_step();
    check("hblank_rgb", {20'd0, red, green, blue}, 32'h0000_0A37);
    pix_step();
    check("hblank_dly", {30'd0, LHBL_dly, LVBL_dly}, 32'd1);
    check("hblank_zero", {20'd0, red, green, blue}, 32'd0);
    LVBL = 1'b0; pix_step();
    LVBL = 1'b1; repeat (3) pix_step();

    // Write collision on 0x40: pixel read in the write cycle sees the old byte
    set_pix(2'd3, 4'd0, 3'd0, 3'd0, 1'b0, 6'h00);
    pix_step();
    set_wr(8'h40, 8'hFF, 1'b1, 1'b0);
    pix_step();
    pix_step();
    check("collide_old", {24'd0, red, green}, 32'd0);
    pix_step();
    check("collide_new", {24'd0, red, green}, 32'h0000_00FF);

    // Random pixels, blanking and palette writes in and out of pixel ticks
    for (int n = 0; n < 250; n++) begin
      set_pix(($urandom % 2) ? 2'd3 : 2'($urandom), 4'($urandom), 3'($urandom),
              3'($urandom), 1'($urandom), ($urandom % 3 == 0) ? 6'h0F : 6'($urandom));
      LHBL = ($urandom % 6) != 0;
      LVBL = ($urandom % 10) != 0;
      if ($urandom % 4 == 0) set_wr(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      pix_step();
      if ($urandom % 5 == 0) begin
        set_wr(8'($urandom), 8'($urandom), 1'b1, 1'b1);
        tick(1'b0);
      end
    end

    // Asynchronous reset mid-frame with pixels active
    LHBL = 1'b1; LVBL = 1'b1;
    set_pix(2'd1, 4'd1, 3'd0, 3'd0, 1'b0, 6'h0F);
    repeat (3) pix_step();
    #5 rst = 1'b1;
    #1;
    check("rst_async", {27'd0, red, green, blue, LHBL_dly, LVBL_dly}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    p = 0;
    repeat (3) pix_step();
    check("rst_first_valid", {20'd0, red, green, blue}, 32'h0000_0A37);
    for (int n = 0; n < 20; n++) begin
      set_pix(2'($urandom), 4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 6'($urandom));
      pix_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
